// File: rtl/sram_pkg.sv
// Shared widths, byte-lane indices and FSM encoding for the SRAM responder.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package sram_pkg;

    localparam int SRAM_ADDR_W = 18;
    localparam int SRAM_DATA_W = 16;

    localparam int LANE_W  = 8;
    localparam int LANE_LO = 0;
    localparam int LANE_HI = 1;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WRITE
    } state_e;

endpackage

// File: rtl/sram_responder_if.sv
// Control and address pins of the DE2 async SRAM, seen from controller and chip.
// Latency: n/a (wiring only).
// Backpressure: none; the pins are plain levels sampled every clock.
interface sram_responder_if #(
    parameter int ADDR_W = sram_pkg::SRAM_ADDR_W
);
    logic [ADDR_W-1:0] addr;
    logic              ce_n;
    logic              we_n;
    logic              oe_n;
    logic              ub_n;
    logic              lb_n;

    modport master (output addr, ce_n, we_n, oe_n, ub_n, lb_n);
    modport slave  (input  addr, ce_n, we_n, oe_n, ub_n, lb_n);
endinterface

// File: rtl/sram_resp_array.sv
// Single-port word array with per-byte write enables and a registered read port.
// Latency: read data appears one clk after rd_addr; writes land at the clk edge.
// Backpressure: none; one write and one read may be presented every clk.
module sram_resp_array
    import sram_pkg::*;
#(
    parameter int AW = 18,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [1:0]    wr_be,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_dat,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_dat
);

    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic [DW-1:0] rd_dat_d, rd_dat_q;

    always_comb begin
        rd_dat_d = mem[rd_addr];
    end

    // Contents are deliberately never cleared, like the real chip.
    always_ff @(posedge clk) begin
        rd_dat_q <= rd_dat_d;
        if (wr_en && wr_be[LANE_LO])
            mem[wr_addr][LANE_LO*LANE_W +: LANE_W] <= wr_dat[LANE_LO*LANE_W +: LANE_W];
        if (wr_en && wr_be[LANE_HI])
            mem[wr_addr][LANE_HI*LANE_W +: LANE_W] <= wr_dat[LANE_HI*LANE_W +: LANE_W];
    end

    assign rd_dat = rd_dat_q;

endmodule

// File: rtl/sram_responder.sv
// Clocked stand-in for the 256Kx16 async SRAM: samples pins, stores words, drives reads.
// Latency: 1 clk pin sample, then READ_LAT clk to read data; write commits 1 clk after we_n high.
// Backpressure: none; the controller owns pin timing, illegal combos raise err_contention.
module sram_responder
    import sram_pkg::*;
#(
    parameter int ADDR_W   = SRAM_ADDR_W,
    parameter int MEM_AW   = 18,
    parameter int DATA_W   = SRAM_DATA_W,
    parameter int READ_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    sram_responder_if.slave   pins,
    inout  wire  [DATA_W-1:0] sram_dq,
    output logic [15:0]       wr_count,
    output logic [15:0]       rd_count,
    output logic              err_contention
);

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] dat;
        logic              ce_n;
        logic              we_n;
        logic              oe_n;
        logic              ub_n;
        logic              lb_n;
    } pins_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] dat;
        logic              ub_n;
        logic              lb_n;
    } cap_t;

    localparam pins_t      SMP_RST = '{addr: '0, dat: '0, ce_n: 1'b1, we_n: 1'b1,
                                       oe_n: 1'b1, ub_n: 1'b1, lb_n: 1'b1};
    localparam logic [2:0] LAT     = 3'(READ_LAT);

    pins_t             smp_d, smp_q;
    cap_t              cap_d, cap_q;
    state_e            state_d, state_q;
    logic [2:0]        lat_d, lat_q;
    logic [ADDR_W-1:0] rd_addr_d, rd_addr_q;
    logic              drive_d, drive_q;
    logic              drv_hi_d, drv_hi_q;
    logic              drv_lo_d, drv_lo_q;
    logic [15:0]       wr_count_d, wr_count_q;
    logic [15:0]       rd_count_d, rd_count_q;
    logic              err_d, err_q;
    logic              wr_req, rd_req, commit, rd_act;
    logic [DATA_W-1:0] rd_dat;

    always_comb begin
        smp_d = '{addr: pins.addr, dat: sram_dq, ce_n: pins.ce_n, we_n: pins.we_n,
                  oe_n: pins.oe_n, ub_n: pins.ub_n, lb_n: pins.lb_n};
    end

    // Requiring we_n=1 for a read is what gives writes priority everywhere.
    assign wr_req = !smp_q.ce_n && !smp_q.we_n;
    assign rd_req = !smp_q.ce_n && smp_q.we_n && !smp_q.oe_n && !(smp_q.ub_n && smp_q.lb_n);

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = IDLE;
        case (state_q)
            IDLE, READ: state_d = wr_req ? WRITE : (rd_req ? READ : IDLE);
            WRITE:      state_d = wr_req ? WRITE : IDLE;
            default:    state_d = IDLE;
        endcase
    end

    // A read sampled in the commit cycle is picked up one sample later, after the array update.
    always_comb begin
        commit = 1'b0;
        rd_act = 1'b0;
        case (state_q)
            IDLE, READ: rd_act = rd_req;
            WRITE:      commit = !wr_req;
            default:    ;
        endcase
    end

    always_comb begin
        if (!rd_act)                     lat_d = '0;
        else if (state_q != READ)        lat_d = 3'd1;
        else if (smp_q.addr != rd_addr_q) lat_d = '0;
        else                             lat_d = (lat_q >= LAT) ? lat_q : lat_q + 3'd1;

        rd_addr_d  = smp_q.addr;
        drive_d    = rd_act && (lat_d >= LAT);
        drv_hi_d   = drive_d && !smp_q.ub_n;
        drv_lo_d   = drive_d && !smp_q.lb_n;

        rd_count_d = rd_count_q;
        if (drive_d && !drive_q) rd_count_d = rd_count_q + 16'd1;

        wr_count_d = wr_count_q;
        if (commit) wr_count_d = wr_count_q + 16'd1;

        cap_d = cap_q;
        if (wr_req) cap_d = '{addr: smp_q.addr, dat: smp_q.dat, ub_n: smp_q.ub_n, lb_n: smp_q.lb_n};

        err_d = err_q || (wr_req && !smp_q.oe_n);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            smp_q      <= SMP_RST;
            lat_q      <= '0;
            rd_addr_q  <= '0;
            drive_q    <= 1'b0;
            drv_hi_q   <= 1'b0;
            drv_lo_q   <= 1'b0;
            wr_count_q <= '0;
            rd_count_q <= '0;
            err_q      <= 1'b0;
        end else begin
            smp_q      <= smp_d;
            lat_q      <= lat_d;
            rd_addr_q  <= rd_addr_d;
            drive_q    <= drive_d;
            drv_hi_q   <= drv_hi_d;
            drv_lo_q   <= drv_lo_d;
            wr_count_q <= wr_count_d;
            rd_count_q <= rd_count_d;
            err_q      <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        cap_q <= cap_d;
    end

    // Gating with rst_n drops a write that is still pending when reset arrives.
    sram_resp_array #(
        .AW (MEM_AW),
        .DW (DATA_W)
    ) u_array (
        .clk     (clk),
        .wr_en   (commit && rst_n),
        .wr_be   ({!cap_q.ub_n, !cap_q.lb_n}),
        .wr_addr (cap_q.addr[MEM_AW-1:0]),
        .wr_dat  (cap_q.dat),
        .rd_addr (smp_q.addr[MEM_AW-1:0]),
        .rd_dat  (rd_dat)
    );

    assign sram_dq[LANE_HI*LANE_W +: LANE_W] = drv_hi_q ? rd_dat[LANE_HI*LANE_W +: LANE_W]
                                                        : {LANE_W{1'bz}};
    assign sram_dq[LANE_LO*LANE_W +: LANE_W] = drv_lo_q ? rd_dat[LANE_LO*LANE_W +: LANE_W]
                                                        : {LANE_W{1'bz}};

    assign wr_count       = wr_count_q;
    assign rd_count       = rd_count_q;
    assign err_contention = err_q;

endmodule

// File: tb/tb_sram_responder.sv
// Directed bench for sram_responder; a released bus reads back as all-ones via pull-ups.
// Latency: n/a.
// Backpressure: n/a.
module tb_sram_responder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        tb_dq_en;
    logic [15:0] tb_dq;
    logic [15:0] wr_count, rd_count;
    logic        err;
    tri   [15:0] dq;
    int          checks = 0;
    int          passes = 0;
    int          fails  = 0;

    always #5 clk = ~clk;

    sram_responder_if #(.ADDR_W(18)) pins ();

    assign dq = tb_dq_en ? tb_dq : 16'hzzzz;

    for (genvar g = 0; g < 16; g++) begin : g_pu
        pullup (dq[g]);
    end

    sram_responder #(
        .ADDR_W   (18),
        .MEM_AW   (18),
        .DATA_W   (16),
        .READ_LAT (1)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .pins           (pins),
        .sram_dq        (dq),
        .wr_count       (wr_count),
        .rd_count       (rd_count),
        .err_contention (err)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_pins(input logic [17:0] a, input logic we, input logic oe,
                            input logic ub, input logic lb);
        pins.addr = a;
        pins.we_n = we;
        pins.oe_n = oe;
        pins.ub_n = ub;
        pins.lb_n = lb;
    endtask

    task automatic do_write(input logic [17:0] a, input logic [15:0] d,
                            input logic ub, input logic lb);
        set_pins(a, 1'b0, 1'b1, ub, lb);
        tb_dq    = d;
        tb_dq_en = 1'b1;
        step();
        step();
        pins.we_n = 1'b1;
        tb_dq_en  = 1'b0;
        step();
        step();
    endtask

    task automatic start_read(input logic [17:0] a, input logic ub, input logic lb);
        set_pins(a, 1'b1, 1'b0, ub, lb);
        step();
        step();
    endtask

    task automatic end_read();
        pins.oe_n = 1'b1;
        step();
        step();
    endtask

    initial begin
        rst_n     = 1'b0;
        tb_dq_en  = 1'b0;
        tb_dq     = '0;
        pins.ce_n = 1'b1;
        set_pins(18'h0, 1'b1, 1'b1, 1'b0, 1'b0);
        repeat (3) step();
        check("rst_dq", dq, 16'hFFFF);
        check("rst_wr_count", wr_count, 16'd0);
        check("rst_rd_count", rd_count, 16'd0);
        check("rst_err", {15'd0, err}, 16'd0);
        rst_n     = 1'b1;
        pins.ce_n = 1'b0;
        step();

        do_write(18'h00010, 16'hBEEF, 1'b0, 1'b0);
        check("wr_beef_count", wr_count, 16'd1);
        start_read(18'h00010, 1'b0, 1'b0);
        check("rd_beef_dq", dq, 16'hBEEF);
        check("rd_beef_count", rd_count, 16'd1);
        end_read();

        do_write(18'h3FFFF, 16'h1234, 1'b0, 1'b0);
        do_write(18'h3FFFF, 16'hAB00, 1'b0, 1'b1);
        start_read(18'h3FFFF, 1'b0, 1'b0);
        check("rd_lb_masked_wr", dq, 16'hAB34);
        end_read();
        start_read(18'h3FFFF, 1'b1, 1'b0);
        check("rd_ub_masked", dq, 16'hFF34);
        end_read();

        do_write(18'h00000, 16'h0A0A, 1'b0, 1'b0);
        do_write(18'h00001, 16'h1B1B, 1'b0, 1'b0);
        do_write(18'h00020, 16'h1111, 1'b0, 1'b0);
        start_read(18'h00000, 1'b0, 1'b0);
        check("addr_chg_first", dq, 16'h0A0A);
        pins.addr = 18'h00001;
        step();
        step();
        check("addr_chg_release", dq, 16'hFFFF);
        step();
        check("addr_chg_second", dq, 16'h1B1B);
        check("addr_chg_rd_count", rd_count, 16'd5);
        end_read();

        start_read(18'h00010, 1'b0, 1'b0);
        check("cont_read_dq", dq, 16'hBEEF);
        pins.we_n = 1'b0;
        step();
        step();
        check("cont_release", dq, 16'hFFFF);
        check("cont_err", {15'd0, err}, 16'd1);
        pins.oe_n = 1'b1;
        tb_dq     = 16'hC0DE;
        tb_dq_en  = 1'b1;
        step();
        pins.we_n = 1'b1;
        tb_dq_en  = 1'b0;
        step();
        step();
        check("cont_wr_count", wr_count, 16'd7);
        start_read(18'h00010, 1'b0, 1'b0);
        check("cont_commit_dq", dq, 16'hC0DE);
        check("cont_rd_count", rd_count, 16'd7);
        end_read();
        check("err_sticky", {15'd0, err}, 16'd1);

        set_pins(18'h00020, 1'b0, 1'b1, 1'b0, 1'b0);
        tb_dq    = 16'h5555;
        tb_dq_en = 1'b1;
        step();
        step();
        rst_n = 1'b0;
        step();
        pins.we_n = 1'b1;
        tb_dq_en  = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
        check("rstw_wr_count", wr_count, 16'd0);
        check("rstw_rd_count", rd_count, 16'd0);
        check("rstw_err", {15'd0, err}, 16'd0);
        start_read(18'h00020, 1'b0, 1'b0);
        check("rstw_mem_kept", dq, 16'h1111);
        end_read();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/sram_responder.md
# sram_responder

Clocked, synthesizable responder for the asynchronous 256K×16 SRAM pin interface on the DE2 board. It sits on the far side of the SRAM controller's pins, in place of the physical chip in simulation and in FPGA loop-back builds. It decodes chip-enable, write-enable, output-enable and byte masks, stores words in an internal array, and drives read data back onto the shared bidirectional bus with a fixed latency. It also counts completed accesses and flags illegal pin combinations so the controller and the I2S buffering logic above it can be checked against a well-defined SRAM.

## Interface
Parameters:
- ADDR_W, 18, address width on the pins
- MEM_AW, 18, implemented array address bits; upper ADDR_W-MEM_AW address bits are ignored (aliasing)
- DATA_W, 16, data width; must be 16 (two byte lanes)
- READ_LAT, 1, clk cycles from a sampled read request to data on sram_dq (1..4)

Ports:
- clk  in  1  single clock; all pins are synchronous to it
- rst_n  in  1  reset, synchronous, active-low
- sram_addr  in  ADDR_W  word address
- sram_dq  inout  16  shared data bus; responder drives it only during reads, otherwise high-Z
- sram_ce_n  in  1  chip enable, active-low
- sram_we_n  in  1  write enable, active-low
- sram_oe_n  in  1  output enable, active-low
- sram_ub_n  in  1  upper byte [15:8] enable, active-low
- sram_lb_n  in  1  lower byte [7:0] enable, active-low
- wr_count  out  16  committed writes, wraps at 0xFFFF→0
- rd_count  out  16  completed reads, wraps
- err_contention  out  1  sticky; set when ce_n=0, we_n=0 and oe_n=0 are sampled together

## Operation
- One input register stage samples all pins each clk. All decisions use the sampled values.
- States:
  - IDLE
  - READ: ce_n=0, we_n=1, oe_n=0, with at least one byte lane enabled
  - WRITE: ce_n=0, we_n=0
- IDLE→WRITE when a write is sampled. Write takes priority over read in every case.
- IDLE→READ when a read is sampled.
- Write handling:
  - While in WRITE, every cycle captures addr, dq, ub_n and lb_n. The last captured set wins, modelling the real chip latching on the WE rising edge.
  - WRITE→IDLE on the first sample with we_n=1 or ce_n=1. That cycle commits the captured word to the lanes whose mask was 0 and increments wr_count. A write with both lanes masked commits nothing and still counts.
- Read handling:
  - After READ_LAT cycles in READ with a stable address, drive mem[addr] on the enabled lanes. Disabled lanes stay high-Z.
  - rd_count increments once, on the first cycle data is driven.
  - An address change while in READ restarts the latency counter, and dq returns to high-Z until the new data is valid.
- READ→IDLE when ce_n=1 or oe_n=1 is sampled, or when both lanes are masked. dq is released in that same cycle.
- READ→WRITE when we_n=0 is sampled. dq is released immediately and err_contention is set if oe_n is still 0.
- Read-after-write to the same address returns the committed data. The commit completes before any following read.
- Reset:
  - Outputs: dq high-Z, counters 0, err_contention 0, state IDLE.
  - A write pending at reset is discarded.
  - Array contents are not cleared.

## Timing
- Input sample: 1 cycle.
- Read data valid on sram_dq READ_LAT cycles after the cycle the read is sampled, so the pin-to-data latency is READ_LAT+1 clk.
- Write commit: 1 cycle after we_n is sampled high. The array is updated at the end of the commit cycle.
- Minimum write pulse: 1 sampled cycle of we_n=0.
- Back-to-back writes need one sampled we_n=1 cycle between them. Held-low we_n across an address change is treated as a single write that keeps the last address.
- Counters update on the commit cycle and the first-drive cycle. Both are registered outputs.
- Bus release (drive to high-Z): at most 1 cycle after the disabling pin is sampled.

## Structure
- Shared package `sram_pkg`:
  - ADDR_W and DATA_W defaults
  - State enum {IDLE, READ, WRITE}
  - Byte-lane index constants
- One sub-module, `sram_resp_array`: a 2^MEM_AW × 16 single-port array with per-byte write enables and registered read. The read latency pipeline stays in the top level.

## Test plan
- Reset then idle: rst_n=0 for 3 cycles → dq=Z, wr_count=0, rd_count=0, err_contention=0.
- Full-word write then read: write 0xBEEF to addr 0x00010 (we_n low 2 cycles), then read addr 0x00010 with READ_LAT=1 → dq=0xBEEF two cycles after oe_n falls; wr_count=1, rd_count=1.
- Byte masks:
  - Write 0x1234 to 0x3FFFF, then write 0xAB00 with lb_n=1 → read returns 0xAB34.
  - Read with ub_n=1 → dq[15:8]=Z, dq[7:0]=0x34.
- Read address change: hold oe_n=0 and step addr 0x00000→0x00001 → dq goes Z for one cycle, then shows mem[1]; rd_count increments by 2.
- Contention: during an active read, drive we_n=0 with oe_n=0 → dq released within 1 cycle, err_contention=1 and sticky until reset; the write commits.
- Reset mid-write: we_n=0 with data 0x5555 at 0x00020, rst_n=0 before we_n rises → memory at 0x00020 unchanged, wr_count=0.
